// File: rtl/axicb_fifo_drain_arb.sv
// rtl/axicb_fifo_drain_arb.sv - round-robin drain arbiter for an array of store-mode FIFOs
//
// Drains N_FIFO FIFOs onto one valid/ready output through a single registered
// output stage. With PACKET_MODE=1 the grant is held on one FIFO until a word
// with bit DATA_WIDTH-1 (last) set has been pulled.
//
// Optional feature macro: AXICB_ARB_STARVE_EN
//   Adds per-FIFO 8-bit wait counters; a saturated counter overrides the
//   round-robin choice in ARB, and the `starve` output flags saturated counters.
//
// Ports:
//   aclk, aresetn (async active-low), srst (sync active-high, same effect)
//   fifo_empty[N_FIFO]            per-FIFO empty flags
//   fifo_data[N_FIFO*DATA_WIDTH]  per-FIFO head words, FIFO i at [i*DATA_WIDTH +: DATA_WIDTH]
//   fifo_pull[N_FIFO]             one-hot pop strobe (combinational)
//   out_valid/out_ready/out_data  registered output word
//   out_id                        source FIFO index of out_data
//   busy                          packet lock held
//   starve[N_FIFO]                (AXICB_ARB_STARVE_EN only) saturated wait counters
module axicb_fifo_drain_arb #(
    parameter int N_FIFO      = 4,
    parameter int DATA_WIDTH  = 8,
    parameter int PACKET_MODE = 0,
    localparam int IDW        = $clog2(N_FIFO)
) (
    input  logic                         aclk,
    input  logic                         aresetn,
    input  logic                         srst,
    input  logic [N_FIFO-1:0]            fifo_empty,
    input  logic [N_FIFO*DATA_WIDTH-1:0] fifo_data,
    output logic [N_FIFO-1:0]            fifo_pull,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [DATA_WIDTH-1:0]        out_data,
    output logic [IDW-1:0]               out_id,
    output logic                         busy
`ifdef AXICB_ARB_STARVE_EN
    ,
    output logic [N_FIFO-1:0]            starve
`endif
);

    typedef enum logic {ST_ARB, ST_LOCK} state_t;

    state_t                state_q, state_d;
    logic [IDW-1:0]        rr_ptr_q, rr_ptr_d;
    logic [IDW-1:0]        lock_id_q, lock_id_d;
    logic [IDW-1:0]        rr_cand, cand;
    logic                  rr_hit, pull_en, slot;
    logic [IDW:0]          idx_w;
    logic [DATA_WIDTH-1:0] cand_word;

    // Explicit compare so non-power-of-2 N_FIFO wraps correctly.
    function automatic logic [IDW-1:0] ptr_inc(input logic [IDW-1:0] p);
        if (p == IDW'(N_FIFO - 1)) return '0;
        return p + IDW'(1);
    endfunction

    // First non-empty FIFO at or after rr_ptr. Scanning the offsets downward
    // lets the smallest offset overwrite the result last.
    always_comb begin
        rr_cand = '0;
        rr_hit  = 1'b0;
        idx_w   = '0;
        for (int k = N_FIFO - 1; k >= 0; k--) begin
            idx_w = {1'b0, rr_ptr_q} + (IDW+1)'(k);
            if (idx_w >= (IDW+1)'(N_FIFO)) idx_w = idx_w - (IDW+1)'(N_FIFO);
            if (!fifo_empty[idx_w[IDW-1:0]]) begin
                rr_cand = idx_w[IDW-1:0];
                rr_hit  = 1'b1;
            end
        end
    end

`ifdef AXICB_ARB_STARVE_EN
    logic [7:0]     wait_cnt [N_FIFO];
    logic [IDW-1:0] starve_cand;
    logic           starve_hit;

    always_comb begin
        starve      = '0;
        starve_cand = '0;
        starve_hit  = 1'b0;
        for (int i = N_FIFO - 1; i >= 0; i--) begin
            starve[i] = (wait_cnt[i] == 8'hFF);
            if (starve[i] && !fifo_empty[i]) begin
                starve_cand = IDW'(i);
                starve_hit  = 1'b1;
            end
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            for (int i = 0; i < N_FIFO; i++) wait_cnt[i] <= '0;
        end else if (srst) begin
            for (int i = 0; i < N_FIFO; i++) wait_cnt[i] <= '0;
        end else begin
            for (int i = 0; i < N_FIFO; i++) begin
                if (fifo_pull[i]) wait_cnt[i] <= '0;
                else if (!fifo_empty[i] && !starve[i]) wait_cnt[i] <= wait_cnt[i] + 8'd1;
            end
        end
    end
`endif

    always_comb begin
        state_d   = state_q;
        rr_ptr_d  = rr_ptr_q;
        lock_id_d = lock_id_q;
        fifo_pull = '0;
        slot      = ~out_valid | out_ready;
        cand      = rr_cand;
        pull_en   = 1'b0;
        if (state_q == ST_LOCK) begin
            // Only the locked FIFO is eligible; an empty one just leaves a bubble.
            cand    = lock_id_q;
            pull_en = slot & ~fifo_empty[lock_id_q];
        end else begin
`ifdef AXICB_ARB_STARVE_EN
            if (starve_hit) cand = starve_cand;
            pull_en = slot & (rr_hit | starve_hit);
`else
            pull_en = slot & rr_hit;
`endif
        end
        cand_word = fifo_data[cand*DATA_WIDTH +: DATA_WIDTH];
        if (pull_en) begin
            fifo_pull[cand] = 1'b1;
            if (state_q == ST_LOCK) begin
                if (cand_word[DATA_WIDTH-1]) begin
                    state_d  = ST_ARB;
                    rr_ptr_d = ptr_inc(lock_id_q);
                end
            end else if (PACKET_MODE != 0 && !cand_word[DATA_WIDTH-1]) begin
                state_d   = ST_LOCK;
                lock_id_d = cand;
            end else begin
                rr_ptr_d = ptr_inc(cand);
            end
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q   <= ST_ARB;
            rr_ptr_q  <= '0;
            lock_id_q <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_id    <= '0;
        end else if (srst) begin
            state_q   <= ST_ARB;
            rr_ptr_q  <= '0;
            lock_id_q <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_id    <= '0;
        end else begin
            state_q   <= state_d;
            rr_ptr_q  <= rr_ptr_d;
            lock_id_q <= lock_id_d;
            if (pull_en) begin
                out_valid <= 1'b1;
                out_data  <= cand_word;
                out_id    <= cand;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

    assign busy = (state_q == ST_LOCK);

endmodule

// File: tb/tb_axicb_fifo_drain_arb.sv
// tb/tb_axicb_fifo_drain_arb.sv - self-checking bench for axicb_fifo_drain_arb
module tb_axicb_fifo_drain_arb;
    localparam int N = 4;

    logic aclk = 1'b0;
    always #5 aclk = ~aclk;

    logic       aresetn, srst;
    logic [3:0] emp    [2];
    logic [31:0] dat   [2];
    logic       rdy    [2];
    logic [3:0] pull_o [2];
    logic       ov     [2];
    logic [7:0] od     [2];
    logic [1:0] oid    [2];
    logic       bsy    [2];
`ifdef AXICB_ARB_STARVE_EN
    logic [3:0] stv    [2];
`endif

    axicb_fifo_drain_arb #(.N_FIFO(4), .DATA_WIDTH(8), .PACKET_MODE(0)) dut0 (
        .aclk(aclk), .aresetn(aresetn), .srst(srst),
        .fifo_empty(emp[0]), .fifo_data(dat[0]), .fifo_pull(pull_o[0]),
        .out_valid(ov[0]), .out_ready(rdy[0]), .out_data(od[0]), .out_id(oid[0]),
        .busy(bsy[0])
`ifdef AXICB_ARB_STARVE_EN
        , .starve(stv[0])
`endif
    );

    axicb_fifo_drain_arb #(.N_FIFO(4), .DATA_WIDTH(8), .PACKET_MODE(1)) dut1 (
        .aclk(aclk), .aresetn(aresetn), .srst(srst),
        .fifo_empty(emp[1]), .fifo_data(dat[1]), .fifo_pull(pull_o[1]),
        .out_valid(ov[1]), .out_ready(rdy[1]), .out_data(od[1]), .out_id(oid[1]),
        .busy(bsy[1])
`ifdef AXICB_ARB_STARVE_EN
        , .starve(stv[1])
`endif
    );

    // FIFO contents (also the environment feeding the DUTs) and reference model state.
    logic [7:0] fq [2][4][$];
    int         ptr [2];
    bit         lk  [2];
    int         lid [2];
    bit         mv  [2];
    logic [7:0] md  [2];
    int         mid [2];
    int         cnt [2][4];
    int         m;
    logic [9:0] hlog [$];
    bit         blog [$];
    logic [3:0] last_pull;
    int         total, bad;

    task automatic refresh();
        for (int mm = 0; mm < 2; mm++)
            for (int i = 0; i < 4; i++) begin
                emp[mm][i] = (fq[mm][i].size() == 0);
                dat[mm][i*8 +: 8] = (fq[mm][i].size() != 0) ? fq[mm][i][0] : 8'h00;
            end
    endtask

    task automatic model_reset();
        for (int mm = 0; mm < 2; mm++) begin
            ptr[mm] = 0; lk[mm] = 0; lid[mm] = 0; mv[mm] = 0; md[mm] = 8'h00; mid[mm] = 0;
            for (int i = 0; i < 4; i++) cnt[mm][i] = 0;
        end
    endtask

    task automatic clear_fifos();
        for (int mm = 0; mm < 2; mm++)
            for (int i = 0; i < 4; i++) fq[mm][i].delete();
    endtask

    // One clock: compare both DUTs against the model, then advance the model.
    task automatic cycle();
        logic [3:0] ep [2];
        int cand [2];
        logic [7:0] w;
        refresh();
        #2;
        for (int mm = 0; mm < 2; mm++) begin
            bit slot, ok;
            int c;
            slot = !mv[mm] || rdy[mm];
            ok = 0;
            c = 0;
            if (lk[mm]) begin
                c = lid[mm];
                ok = fq[mm][c].size() > 0;
            end else begin
`ifdef AXICB_ARB_STARVE_EN
                for (int i = 3; i >= 0; i--)
                    if (cnt[mm][i] == 255 && fq[mm][i].size() > 0) begin c = i; ok = 1; end
`endif
                if (!ok)
                    for (int k = N - 1; k >= 0; k--) begin
                        int i;
                        i = (ptr[mm] + k) % N;
                        if (fq[mm][i].size() > 0) begin c = i; ok = 1; end
                    end
            end
            ep[mm] = (slot && ok) ? 4'(1 << c) : 4'b0000;
            cand[mm] = c;
            total++;
            if (pull_o[mm] !== ep[mm]) begin
                bad++;
                $display("FAIL pull dut%0d t=%0t got=%b exp=%b", mm, $time, pull_o[mm], ep[mm]);
            end
            total++;
            if (ov[mm] !== mv[mm]) begin
                bad++;
                $display("FAIL out_valid dut%0d t=%0t got=%b exp=%b", mm, $time, ov[mm], mv[mm]);
            end
            if (mv[mm]) begin
                total++;
                if (od[mm] !== md[mm] || oid[mm] !== 2'(mid[mm])) begin
                    bad++;
                    $display("FAIL out_word dut%0d t=%0t got=%0d:%h exp=%0d:%h",
                             mm, $time, oid[mm], od[mm], mid[mm], md[mm]);
                end
            end
            total++;
            if (bsy[mm] !== lk[mm]) begin
                bad++;
                $display("FAIL busy dut%0d t=%0t got=%b exp=%b", mm, $time, bsy[mm], lk[mm]);
            end
`ifdef AXICB_ARB_STARVE_EN
            for (int i = 0; i < 4; i++) begin
                total++;
                if (stv[mm][i] !== (cnt[mm][i] == 255)) begin
                    bad++;
                    $display("FAIL starve dut%0d[%0d] t=%0t got=%b exp=%b", mm, i, $time,
                             stv[mm][i], (cnt[mm][i] == 255));
                end
            end
`endif
            if (mm == m) begin
                last_pull = pull_o[mm];
                blog.push_back(bsy[mm]);
                if (ov[mm] && rdy[mm]) hlog.push_back({oid[mm], od[mm]});
            end
        end
        @(posedge aclk);
        #1;
        for (int mm = 0; mm < 2; mm++) begin
            for (int i = 0; i < 4; i++) begin
                if (ep[mm][i]) cnt[mm][i] = 0;
                else if (fq[mm][i].size() > 0 && cnt[mm][i] < 255) cnt[mm][i]++;
            end
            if (ep[mm] != 4'b0000) begin
                w = fq[mm][cand[mm]].pop_front();
                if (mm == 1 && !w[7]) begin
                    lk[mm] = 1; lid[mm] = cand[mm];
                end else begin
                    ptr[mm] = (cand[mm] + 1) % N; lk[mm] = 0;
                end
                mv[mm] = 1; md[mm] = w; mid[mm] = cand[mm];
            end else if (rdy[mm]) begin
                mv[mm] = 0;
            end
        end
        refresh();
    endtask

    task automatic drain();
        int n;
        bit busy_env;
        rdy[m] = 1'b1;
        n = 0;
        busy_env = 1;
        while (busy_env && n < 200) begin
            if (lk[m] && fq[m][lid[m]].size() == 0) fq[m][lid[m]].push_back(8'h80 | 8'($urandom_range(0, 127)));
            cycle();
            n++;
            busy_env = mv[m] || lk[m];
            for (int i = 0; i < 4; i++) if (fq[m][i].size() != 0) busy_env = 1;
        end
        total++;
        if (busy_env) begin
            bad++;
            $display("FAIL drain_timeout dut%0d got=busy exp=idle", m);
        end
    endtask

    task automatic do_srst();
        srst = 1'b1;
        @(posedge aclk);
        #1;
        srst = 1'b0;
        model_reset();
        refresh();
    endtask

    task automatic test_reset();
        aresetn = 1'b0; srst = 1'b0; rdy[0] = 1'b1; rdy[1] = 1'b1; m = 0;
        clear_fifos(); model_reset(); refresh();
        #12;
        for (int mm = 0; mm < 2; mm++) begin
            total++;
            if (ov[mm] !== 1'b0 || od[mm] !== 8'h00 || oid[mm] !== 2'd0 || pull_o[mm] !== 4'b0 || bsy[mm] !== 1'b0) begin
                bad++;
                $display("FAIL reset_state dut%0d got=v%b d%h id%0d p%b b%b exp=all zero",
                         mm, ov[mm], od[mm], oid[mm], pull_o[mm], bsy[mm]);
            end
        end
        @(posedge aclk);
        #1;
        aresetn = 1'b1;
    endtask

    task automatic test_rr_sequence();
        m = 0; hlog.delete(); rdy[0] = 1'b1;
        for (int i = 0; i < 4; i++) begin
            fq[0][i].push_back(8'(8'h10 * i));
            fq[0][i].push_back(8'(8'h10 * i + 1));
        end
        for (int k = 0; k < 10; k++) cycle();
        total++;
        if (hlog.size() != 8) begin
            bad++;
            $display("FAIL rr_count got=%0d exp=8", hlog.size());
        end else begin
            for (int k = 0; k < 8; k++) begin
                logic [9:0] e;
                e = {2'(k % 4), 8'(8'h10 * (k % 4) + k / 4)};
                total++;
                if (hlog[k] !== e) begin
                    bad++;
                    $display("FAIL rr_seq[%0d] got=%h exp=%h", k, hlog[k], e);
                end
            end
        end
    endtask

    task automatic test_stall_toggle();
        logic [7:0] words [3];
        m = 0; hlog.delete();
        for (int k = 0; k < 3; k++) begin
            words[k] = 8'($urandom);
            fq[0][2].push_back(words[k]);
        end
        for (int k = 0; k < 12; k++) begin
            rdy[0] = (k % 2 == 0);
            cycle();
            total++;
            if ((last_pull & 4'b1011) !== 4'b0000) begin
                bad++;
                $display("FAIL stall_pull got=%b exp=0100 or 0000", last_pull);
            end
        end
        drain();
        total++;
        if (hlog.size() != 3 || hlog[0] !== {2'd2, words[0]} || hlog[1] !== {2'd2, words[1]}
            || hlog[2] !== {2'd2, words[2]}) begin
            bad++;
            $display("FAIL stall_words got=%0d entries exp=3 in order", hlog.size());
        end
    endtask

    task automatic test_packet_order();
        m = 1; hlog.delete(); blog.delete(); rdy[1] = 1'b1;
        do_srst();
        fq[1][0].push_back(8'h0A); fq[1][0].push_back(8'h0B); fq[1][0].push_back(8'h8C);
        fq[1][1].push_back(8'h8D);
        for (int k = 0; k < 6; k++) cycle();
        total++;
        if (hlog.size() != 4 || hlog[0] !== 10'h00A || hlog[1] !== 10'h00B
            || hlog[2] !== 10'h08C || hlog[3] !== 10'h18D) begin
            bad++;
            $display("FAIL pkt_order got=%0d entries first=%h exp=00a 00b 08c 18d",
                     hlog.size(), hlog.size() ? hlog[0] : 10'h0);
        end
        total++;
        if (blog[0] !== 1'b0 || blog[1] !== 1'b1 || blog[2] !== 1'b1 || blog[3] !== 1'b0) begin
            bad++;
            $display("FAIL pkt_busy got=%b%b%b%b exp=0110", blog[0], blog[1], blog[2], blog[3]);
        end
    endtask

    task automatic test_packet_gap();
        m = 1; hlog.delete(); rdy[1] = 1'b1;
        fq[1][0].push_back(8'h01); fq[1][0].push_back(8'h02);
        cycle();
        fq[1][3].push_back(8'h83);
        for (int k = 0; k < 5; k++) begin
            cycle();
            total++;
            if (last_pull[3] !== 1'b0) begin
                bad++;
                $display("FAIL gap_no_pull3 got=%b exp=0xxx", last_pull);
            end
        end
        fq[1][0].push_back(8'h84);
        for (int k = 0; k < 4; k++) cycle();
        total++;
        if (hlog.size() != 4 || hlog[0] !== 10'h001 || hlog[1] !== 10'h002
            || hlog[2] !== 10'h084 || hlog[3] !== 10'h383) begin
            bad++;
            $display("FAIL gap_order got=%0d entries exp=001 002 084 383", hlog.size());
        end
    endtask

    task automatic test_reset_in_lock();
        m = 1; rdy[1] = 1'b1;
        fq[1][1].push_back(8'h81);
        cycle(); cycle();
        fq[1][2].push_back(8'h12); fq[1][2].push_back(8'h93);
        fq[1][0].push_back(8'h85);
        rdy[1] = 1'b0;
        for (int k = 0; k < 3; k++) cycle();
        total++;
        if (ov[1] !== 1'b1 || bsy[1] !== 1'b1) begin
            bad++;
            $display("FAIL lock_setup got=v%b b%b exp=v1 b1", ov[1], bsy[1]);
        end
        #2;
        aresetn = 1'b0;
        #1;
        total++;
        if (ov[1] !== 1'b0 || bsy[1] !== 1'b0 || od[1] !== 8'h00) begin
            bad++;
            $display("FAIL async_reset got=v%b b%b d%h exp=v0 b0 d00", ov[1], bsy[1], od[1]);
        end
        @(posedge aclk);
        #1;
        aresetn = 1'b1;
        model_reset();
        hlog.delete();
        rdy[1] = 1'b1;
        for (int k = 0; k < 4; k++) cycle();
        total++;
        if (hlog.size() != 2 || hlog[0] !== 10'h085 || hlog[1] !== 10'h293) begin
            bad++;
            $display("FAIL after_reset got=%0d entries first=%h exp=085 293",
                     hlog.size(), hlog.size() ? hlog[0] : 10'h0);
        end
    endtask

    task automatic test_random(input int mm);
        m = mm;
        for (int k = 0; k < 300; k++) begin
            if ($urandom_range(0, 2) == 0) begin
                int f;
                logic [7:0] w;
                f = $urandom_range(0, 3);
                w = 8'($urandom);
                if (mm == 1) w[7] = ($urandom_range(0, 2) == 0);
                if (fq[mm][f].size() < 4) fq[mm][f].push_back(w);
            end
            rdy[mm] = ($urandom_range(0, 3) != 0);
            cycle();
        end
        drain();
    endtask

`ifdef AXICB_ARB_STARVE_EN
    task automatic test_starve();
        m = 0;
        do_srst();
        fq[0][1].push_back(8'h31); fq[0][1].push_back(8'h32);
        fq[0][2].push_back(8'h41);
        rdy[0] = 1'b0;
        for (int k = 0; k < 258; k++) cycle();
        total++;
        if (stv[0][1] !== 1'b1) begin
            bad++;
            $display("FAIL starve_flag got=%b exp=1", stv[0][1]);
        end
        rdy[0] = 1'b1;
        cycle();
        total++;
        if (last_pull !== 4'b0010) begin
            bad++;
            $display("FAIL starve_grant got=%b exp=0010", last_pull);
        end
        drain();
    endtask
`endif

    initial begin
        total = 0;
        bad = 0;
        last_pull = 4'b0;
        test_reset();
        test_rr_sequence();
        test_stall_toggle();
        test_packet_order();
        test_packet_gap();
        test_reset_in_lock();
        test_random(0);
        test_random(1);
`ifdef AXICB_ARB_STARVE_EN
        test_starve();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule
